// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the sequential ALU.
package alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD   = 5'b00000,
        OP_ADDC  = 5'b00001,
        OP_SUB   = 5'b00011,
        OP_SUBD  = 5'b00100,
        OP_INC   = 5'b00101,
        OP_DEC   = 5'b00110,
        OP_LSL   = 5'b01000,
        OP_ASR   = 5'b01001,
        OP_PASSA = 5'b10001,
        OP_NOT   = 5'b10010,
        OP_AND   = 5'b10100,
        OP_OR    = 5'b10101,
        OP_XOR   = 5'b10110,
        OP_NAND  = 5'b10111,
        OP_MUL   = 5'b11000
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_SHIFT,
        S_MUL,
        S_DONE
    } state_e;

    // Logic group: top opcode bit set, except the multiplier.
    function automatic logic is_logic(input logic [4:0] op);
        return op[4] && (op != OP_MUL);
    endfunction

endpackage

// File: rtl/alu_addsub.sv
// Combinational W-bit adder with carry-in, carry-out and signed overflow.
module alu_addsub #(
    parameter int W = 16
) (
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_y,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_carry,
    output logic         o_ovf
);

    logic [W:0] w_full;

    assign w_full  = {1'b0, i_x} + {1'b0, i_y} + {{W{1'b0}}, i_cin};
    assign o_sum   = w_full[W-1:0];
    assign o_carry = w_full[W];
    // Operands of equal sign producing a result of the other sign.
    assign o_ovf   = (i_x[W-1] == i_y[W-1]) && (w_full[W-1] != i_x[W-1]);

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle ops, bit-serial shifts and shift-add multiply,
// with a one-cycle done pulse feeding the condition-code register.
module alu_seq
    import alu_pkg::*;
#(
    parameter int W   = 16,
    parameter int SHW = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [4:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] result,
    output logic         Z,
    output logic         C,
    output logic         S,
    output logic         O,
    output logic [4:0]   op_out,
    output logic         busy,
    output logic         done
);

    localparam int MCW = $clog2(W + 1);
    localparam int CW  = (SHW > MCW) ? SHW : MCW;

    state_e         r_state, w_next;
    logic [4:0]     r_op;
    logic [W-1:0]   r_a, r_b, r_result;
    logic [2*W-1:0] r_acc;
    logic [CW-1:0]  r_cnt;
    logic           r_sc, r_z, r_c, r_s, r_o;

    logic [W-1:0]   w_x, w_y, w_sum, w_res, w_hi, w_lo, w_hi_s, w_shl, w_asr;
    logic           w_cin, w_carry, w_ovf, w_c, w_o, w_mul_o;

    alu_addsub #(.W(W)) u_addsub (
        .i_x    (w_x),
        .i_y    (w_y),
        .i_cin  (w_cin),
        .o_sum  (w_sum),
        .o_carry(w_carry),
        .o_ovf  (w_ovf)
    );

    // Adder is time-shared: accumulate step in MUL, arithmetic op otherwise.
    always_comb begin
        w_x   = r_a;
        w_y   = r_b;
        w_cin = 1'b0;
        if (r_state == S_MUL) begin
            w_x = r_acc[2*W-1:W];
            w_y = r_acc[0] ? r_a : '0;
        end else begin
            case (r_op)
                OP_ADDC: w_cin = 1'b1;
                OP_SUB:  begin w_y = ~r_b; w_cin = 1'b1; end
                OP_SUBD: w_y = ~r_b;
                OP_INC:  begin w_y = '0;   w_cin = 1'b1; end
                OP_DEC:  w_y = '1;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_o   = 1'b0;
        if (is_logic(r_op)) begin
            case (r_op)
                OP_PASSA: w_res = r_a;
                OP_NOT:   w_res = ~r_a;
                OP_AND:   w_res = r_a & r_b;
                OP_OR:    w_res = r_a | r_b;
                OP_XOR:   w_res = r_a ^ r_b;
                OP_NAND:  w_res = ~(r_a & r_b);
                default:  w_res = '0;
            endcase
        end else begin
            case (r_op)
                OP_ADD, OP_ADDC, OP_SUB, OP_SUBD, OP_INC, OP_DEC: begin
                    w_res = w_sum;
                    w_c   = w_carry;
                    w_o   = w_ovf;
                end
                default: ;
            endcase
        end
    end

    assign w_shl = {r_acc[W-2:0], 1'b0};
    assign w_asr = {r_acc[W-1], r_acc[W-1:1]};
    assign w_hi  = r_acc[2*W-1:W];
    assign w_lo  = r_acc[W-1:0];
    // Unsigned-to-signed correction of the upper half: subtract b (a) when a (b) is negative.
    assign w_hi_s  = w_hi - (r_a[W-1] ? r_b : '0) - (r_b[W-1] ? r_a : '0);
    assign w_mul_o = (w_hi_s != {W{w_lo[W-1]}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_LSL || op == OP_ASR) w_next = S_SHIFT;
                    else if (op == OP_MUL)            w_next = S_MUL;
                    else                              w_next = S_EXEC;
                end
            end
            S_EXEC:  w_next = S_DONE;
            S_SHIFT: if (r_cnt == '0) w_next = S_DONE;
            S_MUL:   if (r_cnt == '0) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_EXEC) || (r_state == S_SHIFT) || (r_state == S_MUL);
        done = (r_state == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sc     <= 1'b0;
            r_result <= '0;
            r_z      <= 1'b0;
            r_c      <= 1'b0;
            r_s      <= 1'b0;
            r_o      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op <= op;
                        r_a  <= a;
                        r_b  <= b;
                        r_sc <= 1'b0;
                        if (op == OP_MUL) begin
                            r_acc <= {{W{1'b0}}, b};
                            r_cnt <= CW'(W);
                        end else begin
                            r_acc <= {{W{1'b0}}, a};
                            r_cnt <= CW'(b[SHW-1:0]);
                        end
                    end
                end
                S_EXEC: begin
                    r_result <= w_res;
                    r_z      <= (w_res == '0);
                    r_c      <= w_c;
                    r_s      <= w_res[W-1];
                    r_o      <= w_o;
                end
                S_SHIFT: begin
                    if (r_cnt != '0) begin
                        r_acc[W-1:0] <= (r_op == OP_LSL) ? w_shl : w_asr;
                        r_sc         <= (r_op == OP_LSL) ? r_acc[W-1] : r_acc[0];
                        r_cnt        <= r_cnt - CW'(1);
                    end else begin
                        r_result <= w_lo;
                        r_z      <= (w_lo == '0);
                        r_c      <= r_sc;
                        r_s      <= w_lo[W-1];
                        r_o      <= 1'b0;
                    end
                end
                S_MUL: begin
                    if (r_cnt != '0) begin
                        r_acc <= {w_carry, w_sum, r_acc[W-1:1]};
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        r_result <= w_lo;
                        r_z      <= (w_lo == '0);
                        r_c      <= |w_hi;
                        r_s      <= w_lo[W-1];
                        r_o      <= w_mul_o;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;
    assign Z      = r_z;
    assign C      = r_c;
    assign S      = r_s;
    assign O      = r_o;
    assign op_out = r_op;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vector table, reset abort sequence and
// randomized operations against an arithmetic reference model.
module tb_alu_seq;

  localparam int W   = 16;
  localparam int SHW = 4;
  localparam longint MAXS = (longint'(1) << (W - 1)) - 1;
  localparam longint MINS = -(longint'(1) << (W - 1));

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [4:0]   op;
  logic [W-1:0] a, b;
  logic [W-1:0] result;
  logic         Z, C, S, O;
  logic [4:0]   op_out;
  logic         busy, done;

  int n_checks = 0;
  int n_fails  = 0;

  alu_seq #(.W(W), .SHW(SHW)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .result(result), .Z(Z), .C(C), .S(S), .O(O),
    .op_out(op_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [3:0]   flags;   // {Z, C, S, O}
    int           lat;
    bit           noisy;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit sovf(input longint v);
    return (v > MAXS) || (v < MINS);
  endfunction

  // Reference: plain wide arithmetic on the operand values.
  function automatic void model(input logic [4:0] m_op, input logic [W-1:0] m_a, input logic [W-1:0] m_b,
                                output logic [W-1:0] m_res, output logic [3:0] m_flags, output int m_lat);
    longint ua, ub, sa, sb, r;
    int     k;
    logic   c, o;
    ua = longint'(m_a);
    ub = longint'(m_b);
    sa = longint'($signed(m_a));
    sb = longint'($signed(m_b));
    k  = int'(m_b[SHW-1:0]);
    c = 1'b0; o = 1'b0; m_lat = 2; r = 0;
    case (m_op)
      5'b00000: begin r = ua + ub;     c = r[W];      o = sovf(sa + sb);     end
      5'b00001: begin r = ua + ub + 1; c = r[W];      o = sovf(sa + sb + 1); end
      5'b00011: begin r = ua - ub;     c = (ua >= ub); o = sovf(sa - sb);    end
      5'b00100: begin r = ua - ub - 1; c = (ua > ub);  o = sovf(sa - sb - 1); end
      5'b00101: begin r = ua + 1;      c = r[W];      o = sovf(sa + 1);      end
      5'b00110: begin r = ua - 1;      c = (ua != 0); o = sovf(sa - 1);      end
      5'b01000: begin
        r = ua << k;
        c = (k == 0) ? 1'b0 : 1'(((ua >> (W - k)) & 1) != 0);
        m_lat = k + 2;
      end
      5'b01001: begin
        r = sa >>> k;
        c = (k == 0) ? 1'b0 : 1'(((ua >> (k - 1)) & 1) != 0);
        m_lat = k + 2;
      end
      5'b10001: r = ua;
      5'b10010: r = ~ua;
      5'b10100: r = ua & ub;
      5'b10101: r = ua | ub;
      5'b10110: r = ua ^ ub;
      5'b10111: r = ~(ua & ub);
      5'b11000: begin
        r = ua * ub;
        c = ((r >> W) != 0);
        o = sovf(sa * sb);
        m_lat = W + 2;
      end
      default: r = 0;
    endcase
    m_res   = r[W-1:0];
    m_flags = {(m_res == '0), c, m_res[W-1], o};
  endfunction

  task automatic run_and_check(input string tag, input logic [4:0] t_op, input logic [W-1:0] t_a,
                               input logic [W-1:0] t_b, input logic [W-1:0] e_res,
                               input logic [3:0] e_flags, input int e_lat, input bit noisy);
    int lat;
    op = t_op; a = t_a; b = t_b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    while (!done && lat < 64) begin
      if (noisy) begin
        start = 1'($urandom_range(0, 1));
        op    = 5'($urandom);
        a     = W'($urandom);
        b     = W'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    if (!done) begin
      n_checks++;
      n_fails++;
      $display("FAIL %s_timeout: actual=no_done required=done", tag);
    end
    check({tag, "_result"}, 32'(result), 32'(e_res));
    check({tag, "_flags_zcso"}, 32'({Z, C, S, O}), 32'(e_flags));
    check({tag, "_op_out"}, 32'(op_out), 32'(t_op));
    check({tag, "_latency"}, 32'(lat), 32'(e_lat));
    if (noisy) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_idle_after_done"}, 32'({busy, done}), 32'd0);
    check({tag, "_result_held"}, 32'(result), 32'(e_res));
  endtask

  logic [4:0] valid_ops[15];

  initial begin
    logic [W-1:0] m_res;
    logic [3:0]   m_flags;
    int           m_lat;
    int           n_done;
    logic [4:0]   r_op;
    logic [W-1:0] r_a, r_b;

    valid_ops = '{5'b00000, 5'b00001, 5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01000,
                  5'b01001, 5'b10001, 5'b10010, 5'b10100, 5'b10101, 5'b10110, 5'b10111, 5'b11000};

    tbl[0]  = '{5'b00000, 16'h7FFF, 16'h0001, 16'h8000, 4'b0011, 2,  1'b0};
    tbl[1]  = '{5'b00011, 16'h0005, 16'h0005, 16'h0000, 4'b1100, 2,  1'b0};
    tbl[2]  = '{5'b00011, 16'h0003, 16'h0005, 16'hFFFE, 4'b0010, 2,  1'b0};
    tbl[3]  = '{5'b01001, 16'h8010, 16'h0003, 16'hF002, 4'b0010, 5,  1'b0};
    tbl[4]  = '{5'b01000, 16'h8001, 16'h0000, 16'h8001, 4'b0010, 2,  1'b0};
    tbl[5]  = '{5'b01000, 16'h8001, 16'h0001, 16'h0002, 4'b0100, 3,  1'b0};
    tbl[6]  = '{5'b11000, 16'h0100, 16'h0100, 16'h0000, 4'b1101, 18, 1'b1};
    tbl[7]  = '{5'b11000, 16'hFFFF, 16'h0002, 16'hFFFE, 4'b0110, 18, 1'b1};
    tbl[8]  = '{5'b00010, 16'h1234, 16'h0005, 16'h0000, 4'b1000, 2,  1'b0};
    tbl[9]  = '{5'b10111, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b1000, 2,  1'b0};
    tbl[10] = '{5'b00110, 16'h8000, 16'h0000, 16'h7FFF, 4'b0101, 2,  1'b0};
    tbl[11] = '{5'b00101, 16'hFFFF, 16'h0000, 16'h0000, 4'b1100, 2,  1'b0};
    tbl[12] = '{5'b00001, 16'hFFFF, 16'h0000, 16'h0000, 4'b1100, 2,  1'b0};
    tbl[13] = '{5'b10110, 16'h0F0F, 16'h00FF, 16'h0FF0, 4'b0000, 2,  1'b0};
    tbl[14] = '{5'b00100, 16'h0005, 16'h0005, 16'hFFFF, 4'b0010, 2,  1'b1};

    // Clock/reset
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_result", 32'(result), 32'd0);
    check("reset_flags", 32'({Z, C, S, O}), 32'd0);
    check("reset_op_out", 32'(op_out), 32'd0);
    check("reset_busy_done", 32'({busy, done}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors
    for (int i = 0; i < 15; i++) begin
      run_and_check($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                    tbl[i].res, tbl[i].flags, tbl[i].lat, tbl[i].noisy);
    end

    // Reset in the middle of a multiply
    op = 5'b11000; a = 16'd3; b = 16'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midmul_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("midmul_rst_result", 32'(result), 32'd0);
    check("midmul_rst_flags", 32'({Z, C, S, O}), 32'd0);
    check("midmul_rst_op_out", 32'(op_out), 32'd0);
    check("midmul_rst_busy_done", 32'({busy, done}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      if (done || busy) n_done++;
    end
    check("midmul_no_done_after_abort", 32'(n_done), 32'd0);
    run_and_check("post_abort_add", 5'b00000, 16'd1, 16'd2, 16'd3, 4'b0000, 2, 1'b0);

    // Randomized operations against the model
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 7) == 0) r_op = 5'($urandom_range(0, 31));
      else                           r_op = valid_ops[$urandom_range(0, 14)];
      r_a = W'($urandom);
      r_b = W'($urandom);
      model(r_op, r_a, r_b, m_res, m_flags, m_lat);
      run_and_check($sformatf("rnd%0d", i), r_op, r_a, r_b, m_res, m_flags, m_lat,
                    ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
